// File: rtl/wb_rr_arbiter_if.sv
// Wishbone classic bundle for the two-master/one-slave arbiter.
// 'slave' is the arbiter's view; 'master' is the view of the masters and the shared slave.
interface wb_rr_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [1:0]          m_cyc;
  logic [1:0]          m_stb;
  logic [1:0]          m_we;
  logic [2*AW-1:0]     m_adr;
  logic [2*DW-1:0]     m_dat_w;
  logic [2*DW/8-1:0]   m_sel;
  logic [DW-1:0]       m_dat_r;
  logic [1:0]          m_ack;
  logic [1:0]          m_err;
  logic                s_cyc;
  logic                s_stb;
  logic                s_we;
  logic [AW-1:0]       s_adr;
  logic [DW-1:0]       s_dat_w;
  logic [DW/8-1:0]     s_sel;
  logic [DW-1:0]       s_dat_r;
  logic                s_ack;
  logic                s_err;

  modport slave (
    input  m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel, s_dat_r, s_ack, s_err,
    output m_dat_r, m_ack, m_err, s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel
  );

  modport master (
    output m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel, s_dat_r, s_ack, s_err,
    input  m_dat_r, m_ack, m_err, s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone classic arbiter: two masters share one slave, grant held per cyc burst,
// with a watchdog that errors out strobes the slave never answers.
module wb_rr_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  wb_rr_arbiter_if.slave   bus
);

  localparam int SW = DW / 8;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_fire;

  logic          own_cyc, own_stb, own_we;
  logic [AW-1:0] own_adr;
  logic [DW-1:0] own_dat_w;
  logic [SW-1:0] own_sel;

  always_comb begin
    own_cyc   = bus.m_cyc[owner_q];
    own_stb   = bus.m_stb[owner_q];
    own_we    = bus.m_we[owner_q];
    own_adr   = owner_q ? bus.m_adr[AW +: AW]   : bus.m_adr[0 +: AW];
    own_dat_w = owner_q ? bus.m_dat_w[DW +: DW] : bus.m_dat_w[0 +: DW];
    own_sel   = owner_q ? bus.m_sel[SW +: SW]   : bus.m_sel[0 +: SW];
  end

  // An abandoned transfer (owner already dropped cyc) never produces a watchdog error.
  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);
      assign tmo_fire = (state_q == BUSY) & own_cyc & (tmo_q == TMO_MAX)
                        & ~bus.s_ack & ~bus.s_err;
    end else begin : g_no_wd
      assign tmo_fire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    tmo_d       = tmo_q;
    bus.s_cyc   = 1'b0;
    bus.s_stb   = 1'b0;
    bus.s_we    = 1'b0;
    bus.s_adr   = '0;
    bus.s_dat_w = '0;
    bus.s_sel   = '0;
    bus.m_ack   = 2'b00;
    bus.m_err   = 2'b00;
    bus.m_dat_r = bus.s_dat_r;

    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (|bus.m_cyc) begin
          state_d = BUSY;
          // On a tie the master that did not own the last burst wins.
          owner_d = (&bus.m_cyc) ? ~last_q : bus.m_cyc[1];
        end
      end
      BUSY: begin
        bus.s_cyc             = own_cyc;
        bus.s_stb             = own_stb & ~tmo_fire;
        bus.s_we              = own_we;
        bus.s_adr             = own_adr;
        bus.s_dat_w           = own_dat_w;
        bus.s_sel             = own_sel;
        bus.m_ack[owner_q]    = bus.s_ack;
        bus.m_err[owner_q]    = bus.s_err | tmo_fire;

        if (!own_cyc) begin
          state_d = IDLE;
          last_d  = owner_q;
          tmo_d   = '0;
        end else if ((TIMEOUT > 0) && own_stb && !tmo_fire && !bus.s_ack && !bus.s_err) begin
          tmo_d = tmo_q + 1'b1;
        end else begin
          tmo_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: stimulus pushes expected grants/responses, a negedge monitor checks them.
module tb_wb_rr_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TMO = 4;

  typedef struct {
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [31:0] dat;
  } resp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic cyc_prev;

  logic [31:0] grant_q[$];
  resp_t       resp_q[$];

  wb_rr_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  wb_rr_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_resp(input logic [1:0] ack, input logic [1:0] err, input logic [31:0] dat);
    resp_t r;
    r.ack = ack;
    r.err = err;
    r.dat = dat;
    resp_q.push_back(r);
  endtask

  // Scoreboard monitor: a rising s_cyc is a grant, any ack/err is a response.
  initial cyc_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.s_cyc && !cyc_prev) begin
      if (grant_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_grant actual_adr=%0h required=none", bus.s_adr);
      end else begin
        check("grant_adr", 64'(bus.s_adr), 64'(grant_q.pop_front()));
      end
    end
    cyc_prev <= bus.s_cyc;
    if ((|bus.m_ack) || (|bus.m_err)) begin
      if (resp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp actual_ack=%b err=%b required=none", bus.m_ack, bus.m_err);
      end else begin
        resp_t r;
        r = resp_q.pop_front();
        check("resp_ack_err_dat", {28'd0, bus.m_ack, bus.m_err, bus.m_dat_r},
              {28'd0, r.ack, r.err, r.dat});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.m_cyc = '0; bus.m_stb = '0; bus.m_we = '0; bus.m_adr = '0;
    bus.m_dat_w = '0; bus.m_sel = '0;
    bus.s_dat_r = '0; bus.s_ack = 1'b0; bus.s_err = 1'b0;
    repeat (2) step();
    check("rst_s_cyc", 64'(bus.s_cyc), 64'd0);
    check("rst_s_stb", 64'(bus.s_stb), 64'd0);
    check("rst_m_ack", 64'(bus.m_ack), 64'd0);
    check("rst_m_err", 64'(bus.m_err), 64'd0);
    reset = 1'b0;

    // Single master read from m0
    bus.m_adr[0 +: AW] = 32'h10;
    bus.m_cyc = 2'b01; bus.m_stb = 2'b01; bus.m_we = 2'b00;
    #1 check("t1_no_grant_yet", 64'(bus.s_cyc), 64'd0);
    grant_q.push_back(32'h10);
    step();
    check("t1_grant_latency", 64'(bus.s_cyc), 64'd1);
    check("t1_s_stb", 64'(bus.s_stb), 64'd1);
    step();
    step();
    bus.s_dat_r = 32'hDEADBEEF;
    bus.s_ack   = 1'b1;
    push_resp(2'b01, 2'b00, 32'hDEADBEEF);
    #1 check("t1_dat_r", 64'(bus.m_dat_r), 64'hDEADBEEF);
    check("t1_ack1_low", 64'(bus.m_ack[1]), 64'd0);
    step();
    bus.s_ack = 1'b0;
    bus.m_cyc = 2'b00; bus.m_stb = 2'b00;
    #1 check("t1_s_cyc_drop", 64'(bus.s_cyc), 64'd0);
    step();

    // Tie after reset: m0 first, one idle cycle, then m1
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.m_adr = {32'h200, 32'h100};
    bus.m_cyc = 2'b11; bus.m_stb = 2'b11;
    grant_q.push_back(32'h100);
    grant_q.push_back(32'h200);
    step();
    bus.s_dat_r = 32'h0000_0001;
    bus.s_ack   = 1'b1;
    push_resp(2'b01, 2'b00, 32'h0000_0001);
    step();
    bus.s_ack = 1'b0;
    bus.m_cyc = 2'b10; bus.m_stb = 2'b10;
    step();
    check("t2_idle_gap", 64'(bus.s_cyc), 64'd0);
    step();
    check("t2_m1_adr", 64'(bus.s_adr), 64'h200);
    bus.s_dat_r = 32'h0000_0002;
    bus.s_ack   = 1'b1;
    push_resp(2'b10, 2'b00, 32'h0000_0002);
    step();
    bus.s_ack = 1'b0;
    bus.m_cyc = 2'b00; bus.m_stb = 2'b00;
    step();

    // Round-robin fairness with both masters always requesting
    bus.m_adr = {32'h400, 32'h300};
    for (int i = 0; i < 4; i++) begin
      logic own;
      own = (i % 2 == 1);
      bus.m_cyc = 2'b11; bus.m_stb = 2'b11;
      grant_q.push_back(own ? 32'h400 : 32'h300);
      step();
      bus.s_dat_r = 32'h0000_0100 + i;
      bus.s_ack   = 1'b1;
      push_resp(own ? 2'b10 : 2'b01, 2'b00, 32'h0000_0100 + i);
      step();
      bus.s_ack = 1'b0;
      bus.m_cyc[own] = 1'b0;
      bus.m_stb[own] = 1'b0;
      step();
    end
    bus.m_cyc = 2'b00; bus.m_stb = 2'b00;
    step();

    // Burst hold: m1 does three acked writes while m0 waits
    bus.s_dat_r = 32'h0;
    bus.m_adr[AW +: AW] = 32'h500;
    bus.m_sel[4 +: 4]   = 4'hF;
    bus.m_we  = 2'b10;
    bus.m_cyc = 2'b10; bus.m_stb = 2'b10;
    grant_q.push_back(32'h500);
    step();
    bus.m_adr[0 +: AW] = 32'h600;
    bus.m_cyc = 2'b11; bus.m_stb = 2'b11;
    for (int k = 0; k < 3; k++) begin
      bus.m_adr[AW +: AW]   = 32'h500 + 4 * k;
      bus.m_dat_w[DW +: DW] = 32'h1111_0000 + k;
      bus.s_ack = 1'b1;
      push_resp(2'b10, 2'b00, 32'h0);
      #1;
      check("t4_s_adr", 64'(bus.s_adr), 64'(32'h500 + 4 * k));
      check("t4_s_dat_w", 64'(bus.s_dat_w), 64'(32'h1111_0000 + k));
      check("t4_s_sel_we", {59'd0, bus.s_sel, bus.s_we}, {59'd0, 4'hF, 1'b1});
      step();
    end
    bus.s_ack = 1'b0;
    bus.m_we  = 2'b00;
    bus.m_cyc = 2'b01; bus.m_stb = 2'b01;
    grant_q.push_back(32'h600);
    #1 check("t4_s_cyc_drop", 64'(bus.s_cyc), 64'd0);
    step();
    check("t4_idle_gap", 64'(bus.s_cyc), 64'd0);
    step();
    bus.s_ack = 1'b1;
    push_resp(2'b01, 2'b00, 32'h0);
    step();
    bus.s_ack = 1'b0;
    bus.m_cyc = 2'b00; bus.m_stb = 2'b00;
    step();

    // Timeout: slave never answers m0
    bus.m_adr[0 +: AW] = 32'h700;
    bus.m_cyc = 2'b01; bus.m_stb = 2'b01;
    grant_q.push_back(32'h700);
    step();
    for (int c = 1; c <= 4; c++) begin
      check("t5_stb_before_tmo", 64'(bus.s_stb), 64'd1);
      check("t5_no_err_before_tmo", 64'(bus.m_err), 64'd0);
      step();
    end
    push_resp(2'b00, 2'b01, 32'h0);
    check("t5_tmo_err", 64'(bus.m_err), 64'd1);
    check("t5_tmo_stb_low", 64'(bus.s_stb), 64'd0);
    step();
    check("t5_err_single", 64'(bus.m_err), 64'd0);
    check("t5_stb_restart", 64'(bus.s_stb), 64'd1);
    bus.m_cyc = 2'b00; bus.m_stb = 2'b00;
    step();
    step();

    // Ack coinciding with timeout, then async reset mid-burst
    bus.m_adr = {32'h800, 32'h900};
    bus.m_cyc = 2'b10; bus.m_stb = 2'b10;
    grant_q.push_back(32'h800);
    step();
    repeat (4) step();
    bus.s_dat_r = 32'hCAFEF00D;
    bus.s_ack   = 1'b1;
    push_resp(2'b10, 2'b00, 32'hCAFEF00D);
    #1 check("t6_coincide_stb", 64'(bus.s_stb), 64'd1);
    check("t6_coincide_no_err", 64'(bus.m_err), 64'd0);
    step();
    bus.s_ack = 1'b0;
    bus.m_cyc = 2'b11; bus.m_stb = 2'b11;
    #2;
    reset = 1'b1;
    bus.s_ack = 1'b1;
    #1 check("t6_rst_s_cyc", 64'(bus.s_cyc), 64'd0);
    check("t6_rst_s_stb", 64'(bus.s_stb), 64'd0);
    check("t6_rst_no_ack", 64'(bus.m_ack), 64'd0);
    step();
    reset = 1'b0;
    bus.s_ack = 1'b0;
    grant_q.push_back(32'h900);
    step();
    check("t6_regrant_m0", 64'(bus.s_adr), 64'h900);
    bus.s_dat_r = 32'h0000_0BAD;
    bus.s_ack   = 1'b1;
    push_resp(2'b01, 2'b00, 32'h0000_0BAD);
    step();
    bus.s_ack = 1'b0;
    bus.m_cyc = 2'b00; bus.m_stb = 2'b00;
    repeat (3) step();

    check("sb_grant_drained", 64'(grant_q.size()), 64'd0);
    check("sb_resp_drained", 64'(resp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
Two-master, one-slave Wishbone classic arbiter. It shares the rv_soc data bus between the core's data port (master 0) and a second requester (master 1, e.g. a debug or DMA engine). Grants are round-robin and held for the whole cyc burst. A bus-timeout watchdog terminates unacknowledged strobes with an error, so a dead peripheral cannot hang the core.

Parameters:
AW, 32, address width
DW, 32, data width; must be a multiple of 8
TIMEOUT, 255, cycles a strobe may wait for ack/err before the arbiter injects err; 0 disables the watchdog

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
m_cyc  input  2  cyc per master, bit i = master i
m_stb  input  2  stb per master
m_we  input  2  we per master
m_adr  input  2*AW  master i address at [i*AW +: AW]
m_dat_w  input  2*DW  master i write data at [i*DW +: DW]
m_sel  input  2*DW/8  master i byte selects at [i*DW/8 +: DW/8]
m_dat_r  output  DW  read data, s_dat_r broadcast to both masters
m_ack  output  2  ack per master
m_err  output  2  err per master
s_cyc  output  1  slave cyc
s_stb  output  1  slave stb
s_we  output  1  slave we
s_adr  output  AW  slave address
s_dat_w  output  DW  slave write data
s_sel  output  DW/8  slave byte selects
s_dat_r  input  DW  slave read data
s_ack  input  1  slave ack
s_err  input  1  slave err

Behaviour:
- Registered state: state {IDLE, BUSY}, owner (1b), last (1b), tmo_cnt (clog2(TIMEOUT+1) bits, min 1).
- Reset (async, immediate): state=IDLE, owner=0, last=1 (master 0 wins the first tie), tmo_cnt=0.
- In IDLE, all s_* outputs are 0, and m_ack=m_err=0.
- Arbitration (IDLE, rising edge):
  - If exactly one m_cyc bit is high, owner = that master.
  - If both are high, owner = ~last.
  - state becomes BUSY.
  - Grant latency: s_cyc rises 1 cycle after m_cyc is sampled.
- BUSY, combinational paths:
  - s_cyc/stb/we/adr/dat_w/sel come from master[owner]. s_stb is forced 0 in the timeout cycle.
  - m_ack[owner] = s_ack.
  - m_err[owner] = s_err | tmo_fire.
  - Non-owner ack/err = 0.
  - m_dat_r = s_dat_r at all times.
- Release: in BUSY, when m_cyc[owner] is 0 at an edge, state becomes IDLE, last=owner, tmo_cnt=0.
  - s_cyc follows m_cyc[owner] combinationally, so it drops in the same cycle.
  - There is always one IDLE cycle between bursts; a waiting master is granted on the next edge.
- A master holding cyc across multiple stb/ack transfers keeps the grant. The other master waits indefinitely; there is no preemption.
- Watchdog (TIMEOUT>0, BUSY):
  - tmo_cnt increments each cycle with s_stb=1 and s_ack=s_err=0.
  - tmo_cnt clears on ack, err, stb low, or release.
  - tmo_fire = (tmo_cnt == TIMEOUT) & ~s_ack & ~s_err. While it is high, m_err[owner]=1 for that single cycle, s_stb=0, and tmo_cnt clears.
  - If s_ack and the timeout coincide, the ack wins and no err is issued.
- TIMEOUT=0: tmo_fire is tied 0 and the counter is unused.
- Master drops cyc mid-transfer (no ack yet): the transfer is abandoned, release proceeds as above, and no err is generated.
- Reset asserted mid-burst: s_cyc/s_stb drop immediately (asynchronously), and any pending ack is not forwarded.

Test Plan:
- Single master: m0 reads 0x10 (cyc/stb held), slave acks with 0xDEADBEEF after 2 cycles -> s_cyc rises 1 cycle after m_cyc; m_ack=2'b01 for 1 cycle; m_dat_r=0xDEADBEEF; m_ack[1] stays 0.
- Tie after reset: m0 and m1 both assert cyc on the same cycle -> m0 granted first; after m0 drops cyc, 1 IDLE cycle, then m1 granted (s_adr=m1 address).
- Round-robin fairness: both masters request continuously for 4 single-ack bursts -> grant order 0,1,0,1.
- Burst hold: m1 owns the bus and does 3 back-to-back acked writes (sel=4'hF) under one cyc while m0 requests -> all 3 reach the slave uninterrupted; m0 granted only after m1 drops cyc.
- Timeout: TIMEOUT=4, slave never acks -> m_err[owner] pulses exactly once, in the cycle tmo_cnt==4 (5th stb cycle), with s_stb=0 that cycle; master then drops cyc -> IDLE.
- Ack/timeout coincidence plus async reset: s_ack arrives in the tmo_cnt==TIMEOUT cycle -> ack only, no err. Assert reset mid-burst between edges -> s_cyc=0 immediately; the next grant goes to m0 on a tie.
